// File: rtl/bus_pkg.sv
// bus_pkg: shared types and widths for the 32-bit peripheral bus
package bus_pkg;
    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
        logic [3:0]        wmask;
        logic              wen;
        logic              ren;
    } bus_req_t;
endpackage

// File: rtl/arb_rr_pick2.sv
// arb_rr_pick2: two-way round-robin pick, ties go to the master not served last
module arb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);
    assign valid  = |req;
    assign winner = &req ? ~last : req[1];
endmodule

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: two-master round-robin arbiter for the peripheral bus
module bus_arbiter_2m
  import bus_pkg::*;
#(
  parameter int          TIMEOUT       = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  arb_state_t  state, state_nx;
  logic        own, own_nx, last, last_nx;
  logic        win, win_valid, busy, req_own, done, tmo;
  logic [1:0]  req;
  logic [31:0] busy_rdata;
  bus_req_t    m [2];
  bus_req_t    cur;

  assign m[0]    = {m0_addr, m0_wdata, m0_wmask, m0_wen, m0_ren};
  assign m[1]    = {m1_addr, m1_wdata, m1_wmask, m1_wen, m1_ren};
  assign req     = {m1_wen | m1_ren, m0_wen | m0_ren};
  assign busy    = state == ARB_BUSY;
  assign cur     = m[own];
  assign req_own = req[own];
  assign done    = busy & req_own & s_ready;

  arb_rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .winner (win),
    .valid  (win_valid)
  );

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= (busy & ~s_ready) ? cnt + 16'd1 : '0;
      timeout_err <= timeout_err | tmo;
    end
  end
  assign tmo        = busy & req_own & ~s_ready & (cnt == 16'(TIMEOUT));
  assign busy_rdata = tmo ? TIMEOUT_RDATA : s_rdata;
`else
  assign tmo         = 1'b0;
  assign busy_rdata  = s_rdata;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      own   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      own   <= own_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    own_nx   = own;
    last_nx  = last;
    s_addr   = busy ? cur.addr  : '0;
    s_wdata  = busy ? cur.wdata : '0;
    s_wmask  = busy ? cur.wmask : '0;
    s_wen    = busy & cur.wen;
    s_ren    = busy & cur.ren;
    grant    = busy ? (own ? 2'b10 : 2'b01) : 2'b00;
    m0_ready = (done | tmo) & ~own;
    m1_ready = (done | tmo) & own;
    m0_rdata = (busy & ~own) ? busy_rdata : '0;
    m1_rdata = (busy & own) ? busy_rdata : '0;
    if (!busy) begin
      if (win_valid) begin
        state_nx = ARB_BUSY;
        own_nx   = win;
      end
    end else if (done | tmo) begin
      state_nx = ARB_IDLE;
      last_nx  = own;
    end else if (!req_own) begin
      state_nx = ARB_IDLE;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed scoreboard bench for bus_arbiter_2m
module tb_bus_arbiter_2m;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wmask, m1_wmask, s_wmask;
  logic        m0_wen, m0_ren, m0_ready, m1_wen, m1_ren, m1_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_wen, s_ren, s_ready, timeout_err;
  logic [1:0]  grant;
  logic [1:0]  keep = 2'b00;
  int          checks = 0, errors = 0;

  typedef struct {int m; logic [31:0] rd;} exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          gm;
  logic [31:0] grd;

  always #5 clk = ~clk;
  assign s_rdata = s_addr ^ KEY;

  bus_arbiter_2m #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_wen(m0_wen),
    .m0_ren(m0_ren), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_wen(m1_wen),
    .m1_ren(m1_ren), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wen(s_wen), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int mi, input logic [31:0] rd);
    sb.push_back('{mi, rd});
  endtask

  task automatic step();
    logic [1:0] r;
    @(negedge clk);
    r = {m1_ready, m0_ready};
    @(posedge clk);
    #2;
    if (r[0] && !keep[0]) begin m0_wen = 1'b0; m0_ren = 1'b0; end
    if (r[1] && !keep[1]) begin m1_wen = 1'b0; m1_ren = 1'b0; end
  endtask

  always @(negedge clk) begin
    if (m0_ready || m1_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready m0=%b m1=%b required none", m0_ready, m1_ready);
      end else begin
        e   = sb.pop_front();
        gm  = m1_ready ? 1 : 0;
        grd = m1_ready ? m1_rdata : m0_rdata;
        if ((m0_ready && m1_ready) || gm != e.m || grd !== e.rd) begin
          errors++;
          $display("FAIL response got m%0d rdata %h (both=%b) expected m%0d rdata %h",
                   gm, grd, m0_ready && m1_ready, e.m, e.rd);
        end
      end
    end
  end

  initial begin
    m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_wen = 1'b0; m0_ren = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_wen = 1'b0; m1_ren = 1'b0;
    s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_swen", s_wen, 0);
    chk("rst_sren", s_ren, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ready", {m1_ready, m0_ready}, 0);
    s_ready = 1'b1;
    m0_addr = 32'hF000; m0_wdata = 32'h1234_5678; m0_wmask = 4'hF; m0_wen = 1'b1;
    expect_rsp(0, 32'hF000 ^ KEY);
    chk("t1_idle_swen", s_wen, 0);
    step();
    chk("t1_swen", s_wen, 1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_swdata", s_wdata, 32'h1234_5678);
    chk("t1_swmask", s_wmask, 4'hF);
    chk("t1_saddr", s_addr, 32'hF000);
    chk("t1_m0ready", m0_ready, 1);
    chk("t1_m1rdata", m1_rdata, 0);
    step();
    chk("t1_swen_after", s_wen, 0);
    chk("t1_grant_after", grant, 0);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    m0_addr = 32'h100; m1_addr = 32'h200; m0_ren = 1'b1; m1_ren = 1'b1; keep = 2'b11;
    expect_rsp(0, 32'h100 ^ KEY); expect_rsp(1, 32'h200 ^ KEY);
    expect_rsp(0, 32'h100 ^ KEY); expect_rsp(1, 32'h200 ^ KEY);
    step();
    chk("t2_grant_b", grant, 2'b01);
    chk("t2_m1rdata_zero", m1_rdata, 0);
    chk("t2_m0rdata", m0_rdata, 32'h100 ^ KEY);
    step(); step();
    chk("t2_grant_d", grant, 2'b10);
    chk("t2_m0rdata_zero", m0_rdata, 0);
    step(); step();
    chk("t2_grant_f", grant, 2'b01);
    step(); step();
    chk("t2_grant_h", grant, 2'b10);
    keep = 2'b00;
    step();
    m0_ren = 1'b0;
    chk("t2_idle", grant, 0);
    s_ready = 1'b0;
    m1_addr = 32'h300; m1_wdata = 32'hCAFE_0001; m1_wmask = 4'h3; m1_wen = 1'b1;
    step();
    m0_addr = 32'h400; m0_ren = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_grant_stall", grant, 2'b10);
      chk("t3_saddr_stall", s_addr, 32'h300);
      step();
    end
    expect_rsp(1, 32'h300 ^ KEY);
    s_ready = 1'b1;
    chk("t3_grant_done", grant, 2'b10);
    chk("t3_swen_done", s_wen, 1);
    step();
    chk("t3_gap_grant", grant, 0);
    chk("t3_gap_sren", s_ren, 0);
    expect_rsp(0, 32'h400 ^ KEY);
    step();
    chk("t3_m0_grant", grant, 2'b01);
    chk("t3_m0_sren", s_ren, 1);
    step();
    s_ready = 1'b0;
    m0_addr = 32'h500; m0_wen = 1'b1;
    step();
    chk("t4_swen_busy", s_wen, 1);
    rst = 1'b1;
    step();
    chk("t4_swen_rst", s_wen, 0);
    chk("t4_sren_rst", s_ren, 0);
    chk("t4_grant_rst", grant, 0);
    chk("t4_ready_rst", {m1_ready, m0_ready}, 0);
    m0_wen = 1'b0;
    rst = 1'b0;
    s_ready = 1'b1;
    m0_addr = 32'h600; m1_addr = 32'h700; m0_ren = 1'b1; m1_ren = 1'b1;
    expect_rsp(0, 32'h600 ^ KEY); expect_rsp(1, 32'h700 ^ KEY);
    step();
    chk("t4_first_grant", grant, 2'b01);
    step(); step();
    chk("t4_second_grant", grant, 2'b10);
    step();
    chk("t4_idle", grant, 0);
    s_ready = 1'b0;
    m0_addr = 32'h800; m1_addr = 32'h900; m0_ren = 1'b1; m1_ren = 1'b1;
    step();
    chk("t6_grant_m0", grant, 2'b01);
    step();
    chk("t6_grant_m0_hold", grant, 2'b01);
    m0_ren = 1'b0;
    chk("t6_no_ready", m0_ready, 0);
    step();
    chk("t6_idle", grant, 0);
    s_ready = 1'b1;
    expect_rsp(1, 32'h900 ^ KEY);
    step();
    chk("t6_grant_m1", grant, 2'b10);
    step();
`ifdef ARB_TIMEOUT_EN
    s_ready = 1'b0;
    m0_addr = 32'hA00; m0_ren = 1'b1;
    step();
    chk("t5_grant", grant, 2'b01);
    repeat (7) step();
    sb.push_back('{0, 32'hDEAD_BEEF});
    step();
    chk("t5_ready", m0_ready, 1);
    chk("t5_terr_before", timeout_err, 0);
    step();
    chk("t5_terr_set", timeout_err, 1);
    chk("t5_idle", grant, 0);
    step();
    chk("t5_terr_sticky", timeout_err, 1);
`else
    chk("terr_tied", timeout_err, 0);
`endif
    step();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
